// File: rtl/mem_pkg.sv
// mem_pkg: state encoding, mem_op codes, defaults and pipeline register layout
`include "port_define.sv"
package mem_pkg;
    typedef enum logic {IDLE, ACCESS} state_e;
    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;
    localparam int MAX_WAIT_DEF = 16;
    typedef struct packed {
        logic              dm_req;
        logic              dm_we;
        logic [`RegBus]    dm_addr;
        logic [`RegBus]    dm_wdata;
        logic [`RegAddrBus] lat_addr;
        logic              lat_en;
        logic              wb_valid;
        logic              wb_wreg_en;
        logic [`RegAddrBus] wb_wreg_addr;
        logic [`RegBus]    wb_wdata;
        logic              ovf_exc;
        logic              mem_err;
    } regs_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: execute, data-memory and writeback signals of the memory stage
`include "port_define.sv"
interface mem_stage_if;
    logic               ex_valid;
    logic [`RegBus]     ex_alu_result;
    logic [`RegBus]     ex_store_data;
    logic [`RegAddrBus] ex_wreg_addr;
    logic               ex_wreg_en;
    logic [1:0]         ex_mem_op;
    logic               ex_overflow;
    logic               ex_ready;
    logic               dm_req;
    logic               dm_we;
    logic [`RegBus]     dm_addr;
    logic [`RegBus]     dm_wdata;
    logic               dm_ack;
    logic [`RegBus]     dm_rdata;
    logic               wb_valid;
    logic               wb_wreg_en;
    logic [`RegAddrBus] wb_wreg_addr;
    logic [`RegBus]     wb_wdata;
    logic               ovf_exc;
    logic               mem_err;
    modport master (
        output ex_valid, ex_alu_result, ex_store_data, ex_wreg_addr, ex_wreg_en, ex_mem_op, ex_overflow,
        output dm_ack, dm_rdata,
        input  ex_ready, dm_req, dm_we, dm_addr, dm_wdata,
        input  wb_valid, wb_wreg_en, wb_wreg_addr, wb_wdata, ovf_exc, mem_err
    );
    modport slave (
        input  ex_valid, ex_alu_result, ex_store_data, ex_wreg_addr, ex_wreg_en, ex_mem_op, ex_overflow,
        input  dm_ack, dm_rdata,
        output ex_ready, dm_req, dm_we, dm_addr, dm_wdata,
        output wb_valid, wb_wreg_en, wb_wreg_addr, wb_wdata, ovf_exc, mem_err
    );
endinterface

// File: rtl/port_define.sv
// port_define: shared bus-width macros for the memory stage
`ifndef PORT_DEFINE_SV
`define PORT_DEFINE_SV
`define RegBus 31:0
`define RegAddrBus 4:0
`endif

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with aligned load/store, ack timeout and writeback
`include "port_define.sv"
module mem_stage import mem_pkg::*; #(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);
    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    regs_t      r_q, r_d;
    logic       is_mem;
    assign is_mem = bus.ex_mem_op == OP_LOAD || bus.ex_mem_op == OP_STORE;
    assign bus.ex_ready     = state_q == IDLE;
    assign bus.dm_req       = r_q.dm_req;
    assign bus.dm_we        = r_q.dm_we;
    assign bus.dm_addr      = r_q.dm_addr;
    assign bus.dm_wdata     = r_q.dm_wdata;
    assign bus.wb_valid     = r_q.wb_valid;
    assign bus.wb_wreg_en   = r_q.wb_wreg_en;
    assign bus.wb_wreg_addr = r_q.wb_wreg_addr;
    assign bus.wb_wdata     = r_q.wb_wdata;
    assign bus.ovf_exc      = r_q.ovf_exc;
    assign bus.mem_err      = r_q.mem_err;
    // state, wait counter and pipeline registers; reset abandons any transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
        end
    end
    // next state: accept in IDLE, wait for ack or timeout in ACCESS; pulses default low
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        r_d.wb_valid = 1'b0;
        r_d.ovf_exc  = 1'b0;
        r_d.mem_err  = 1'b0;
        if (state_q == IDLE) begin
            if (bus.ex_valid && !is_mem) begin
                r_d.wb_valid     = 1'b1;
                r_d.wb_wdata     = bus.ex_alu_result;
                r_d.wb_wreg_addr = bus.ex_wreg_addr;
                r_d.wb_wreg_en   = bus.ex_wreg_en && !bus.ex_overflow;
                r_d.ovf_exc      = bus.ex_overflow;
            end else if (bus.ex_valid && bus.ex_alu_result[1:0] == 2'b00) begin
                state_d        = ACCESS;
                cnt_d          = '0;
                r_d.dm_req     = 1'b1;
                r_d.dm_we      = bus.ex_mem_op == OP_STORE;
                r_d.dm_addr    = bus.ex_alu_result;
                r_d.dm_wdata   = bus.ex_store_data;
                r_d.lat_addr   = bus.ex_wreg_addr;
                r_d.lat_en     = bus.ex_wreg_en;
            end else if (bus.ex_valid) begin
                r_d.wb_valid   = 1'b1;
                r_d.wb_wreg_en = 1'b0;
                r_d.mem_err    = 1'b1;
            end
        end else if (bus.dm_ack) begin
            state_d          = IDLE;
            r_d.dm_req       = 1'b0;
            r_d.wb_valid     = 1'b1;
            r_d.wb_wreg_addr = r_q.lat_addr;
            r_d.wb_wreg_en   = !r_q.dm_we && r_q.lat_en;
            r_d.wb_wdata     = r_q.dm_we ? r_q.wb_wdata : bus.dm_rdata;
        end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
            state_d        = IDLE;
            r_d.dm_req     = 1'b0;
            r_d.wb_valid   = 1'b1;
            r_d.wb_wreg_en = 1'b0;
            r_d.mem_err    = 1'b1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table vectors, directed corner sequences and random transactions vs a transaction model
module tb_mem_stage;
    localparam int MW = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    mem_stage_if bus();
    mem_stage #(.MAX_WAIT(MW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] alu;
        logic [4:0]  wa;
        logic        we;
        logic        ov;
        logic        een;
        logic        eovf;
        logic        eerr;
        logic        cdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] wa, input logic we, input logic ov);
        bus.ex_valid      = 1'b1;
        bus.ex_mem_op     = op;
        bus.ex_alu_result = alu;
        bus.ex_store_data = sd;
        bus.ex_wreg_addr  = wa;
        bus.ex_wreg_en    = we;
        bus.ex_overflow   = ov;
    endtask

    // single-cycle op: non-memory, reserved, or misaligned memory access
    task automatic do_single(input vec_t v);
        drive(v.op, v.alu, $urandom, v.wa, v.we, v.ov);
        bus.dm_ack = 1'($urandom);
        step();
        bus.ex_valid = 1'b0;
        chk("single.wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("single.wb_wreg_en", 32'(bus.wb_wreg_en), 32'(v.een));
        chk("single.ovf_exc", 32'(bus.ovf_exc), 32'(v.eovf));
        chk("single.mem_err", 32'(bus.mem_err), 32'(v.eerr));
        chk("single.dm_req", 32'(bus.dm_req), 32'd0);
        chk("single.ex_ready", 32'(bus.ex_ready), 32'd1);
        if (v.cdata) begin
            chk("single.wb_wdata", bus.wb_wdata, v.alu);
            chk("single.wb_wreg_addr", 32'(bus.wb_wreg_addr), 32'(v.wa));
        end
    endtask

    // aligned load/store; ack_on is the ACCESS cycle carrying dm_ack (0 or >MW: never)
    task automatic do_mem(input logic [1:0] op, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [4:0] wa, input logic we, input int ack_on);
        logic [31:0] rd;
        logic        acked;
        int          last;
        rd    = $urandom;
        acked = ack_on >= 1 && ack_on <= MW;
        last  = acked ? ack_on : MW;
        drive(op, alu, sd, wa, we, 1'($urandom));
        bus.dm_ack = 1'($urandom);
        step();
        bus.ex_valid = 1'b0;
        for (int k = 1; k <= last; k++) begin
            chk("mem.dm_req", 32'(bus.dm_req), 32'd1);
            chk("mem.dm_we", 32'(bus.dm_we), 32'(op == 2'b10));
            chk("mem.dm_addr", bus.dm_addr, alu);
            if (op == 2'b10) chk("mem.dm_wdata", bus.dm_wdata, sd);
            chk("mem.ex_ready", 32'(bus.ex_ready), 32'd0);
            chk("mem.wb_valid_busy", 32'(bus.wb_valid), 32'd0);
            bus.dm_ack   = k == ack_on;
            bus.dm_rdata = k == ack_on ? rd : $urandom;
            step();
        end
        bus.dm_ack = 1'b0;
        chk("done.dm_req", 32'(bus.dm_req), 32'd0);
        chk("done.wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("done.ex_ready", 32'(bus.ex_ready), 32'd1);
        chk("done.mem_err", 32'(bus.mem_err), 32'(!acked));
        chk("done.wb_wreg_en", 32'(bus.wb_wreg_en), 32'(acked && op == 2'b01 && we));
        if (acked) chk("done.wb_wreg_addr", 32'(bus.wb_wreg_addr), 32'(wa));
        if (acked && op == 2'b01) chk("done.wb_wdata", bus.wb_wdata, rd);
        step();
        chk("after.wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("after.mem_err", 32'(bus.mem_err), 32'd0);
        if (acked && op == 2'b01) chk("after.wb_wdata_hold", bus.wb_wdata, rd);
    endtask

    function automatic vec_t model(input logic [1:0] op, input logic [31:0] alu, input logic [4:0] wa,
                                   input logic we, input logic ov);
        vec_t v;
        logic mem_op;
        mem_op  = op == 2'b01 || op == 2'b10;
        v.op    = op;
        v.alu   = alu;
        v.wa    = wa;
        v.we    = we;
        v.ov    = ov;
        v.eerr  = mem_op;
        v.een   = !mem_op && we && !ov;
        v.eovf  = !mem_op && ov;
        v.cdata = !mem_op;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        tbl[0] = '{2'b00, 32'h0000_0010, 5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{2'b00, 32'hCAFE_0001, 5'd31, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{2'b11, 32'h8000_0003, 5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{2'b00, 32'h1234_5678, 5'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{2'b01, 32'h0000_0102, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{2'b10, 32'h0000_0201, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{2'b11, 32'hFFFF_FFFF, 5'd2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.ex_valid = 1'b0;
        bus.ex_mem_op = 2'b00;
        bus.ex_alu_result = '0;
        bus.ex_store_data = '0;
        bus.ex_wreg_addr = '0;
        bus.ex_wreg_en = 1'b0;
        bus.ex_overflow = 1'b0;
        bus.dm_ack = 1'b0;
        bus.dm_rdata = '0;
        step();
        step();
        chk("rst.ex_ready", 32'(bus.ex_ready), 32'd1);
        chk("rst.dm_req", 32'(bus.dm_req), 32'd0);
        chk("rst.dm_addr", bus.dm_addr, 32'd0);
        chk("rst.wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst.wb_wdata", bus.wb_wdata, 32'd0);
        chk("rst.wb_wreg_en", 32'(bus.wb_wreg_en), 32'd0);
        chk("rst.ovf_exc", 32'(bus.ovf_exc), 32'd0);
        chk("rst.mem_err", 32'(bus.mem_err), 32'd0);
        rst = 1'b1;
        chk("release.ex_ready", 32'(bus.ex_ready), 32'd1);
        for (int i = 0; i < 7; i++) do_single(tbl[i]);
        step();
        chk("table.wb_valid_drop", 32'(bus.wb_valid), 32'd0);
        chk("table.wb_wdata_hold", bus.wb_wdata, 32'hFFFF_FFFF);
        do_mem(2'b01, 32'h0000_0100, 32'h0, 5'd4, 1'b1, 3);
        do_mem(2'b10, 32'h0000_0204, 32'h1234, 5'd6, 1'b1, 0);
        do_mem(2'b01, 32'h0000_0300, 32'h0, 5'd8, 1'b1, MW);
        do_mem(2'b10, 32'h0000_0400, 32'h55AA, 5'd8, 1'b1, 1);
        drive(2'b01, 32'h0000_0100, 32'h0, 5'd4, 1'b1, 1'b0);
        step();
        bus.ex_valid = 1'b0;
        step();
        chk("arst.dm_req_before", 32'(bus.dm_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst.dm_req_async", 32'(bus.dm_req), 32'd0);
        chk("arst.ex_ready_async", 32'(bus.ex_ready), 32'd1);
        bus.dm_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("arst.wb_valid", 32'(bus.wb_valid), 32'd0);
        end
        bus.dm_ack = 1'b0;
        rst = 1'b1;
        chk("arst.ex_ready_release", 32'(bus.ex_ready), 32'd1);
        step();
        chk("arst.wb_valid_after", 32'(bus.wb_valid), 32'd0);
        chk("arst.dm_req_after", 32'(bus.dm_req), 32'd0);
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic [31:0] alu;
            op  = 2'($urandom);
            alu = $urandom;
            if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
            if ((op == 2'b01 || op == 2'b10) && alu[1:0] == 2'b00) begin
                bus.ex_valid = 1'b0;
                do_mem(op, alu, $urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, MW + 2)));
            end else begin
                do_single(model(op, alu, 5'($urandom), 1'($urandom), 1'($urandom)));
            end
        end
        bus.ex_valid = 1'b0;
        step();
        step();
        chk("end.wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("end.ex_ready", 32'(bus.ex_ready), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 16, giving the dm_ack timeout in cycles (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the execute-stage input ports: ex_valid (1 bit); ex_alu_result (`RegBus, the address or arithmetic result); ex_store_data (`RegBus); ex_wreg_addr (`RegAddrBus); ex_wreg_en (1 bit); ex_mem_op (2 bits: 00 none, 01 load, 10 store, 11 reserved); ex_overflow (1 bit).
REQ-005 The block SHALL have output ex_ready (1 bit): the block can accept an operation this cycle.
REQ-006 The block SHALL have data-memory outputs dm_req (1), dm_we (1), dm_addr (`RegBus) and dm_wdata (`RegBus).
REQ-007 The block SHALL have data-memory inputs dm_ack (1) and dm_rdata (`RegBus).
REQ-008 The block SHALL have writeback outputs wb_valid (1), wb_wreg_en (1), wb_wreg_addr (`RegAddrBus) and wb_wdata (`RegBus).
REQ-009 The block SHALL have exception outputs ovf_exc (1-cycle pulse) and mem_err (1-cycle pulse).

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and ACCESS.
REQ-011 ex_ready SHALL equal (state==IDLE), decoded combinationally from the state register.
REQ-012 The block SHALL accept an operation only on a clock edge where ex_valid && ex_ready.
REQ-013 On accept of mem_op 00 or 11, the next cycle SHALL show wb_valid=1, wb_wdata=ex_alu_result, wb_wreg_addr=ex_wreg_addr and wb_wreg_en=ex_wreg_en && !ex_overflow (latency 1); the state SHALL remain IDLE.
REQ-014 When a non-memory op is accepted with ex_overflow=1, ovf_exc SHALL pulse in the same cycle as wb_valid.
REQ-015 On accept of a load or store with ex_alu_result[1:0]==0, the block SHALL latch addr, data, we (store=1) and the destination register, then enter ACCESS; dm_req SHALL be 1 from the next cycle.
REQ-016 On accept of a load or store with ex_alu_result[1:0]!=0 (misaligned), the block SHALL issue no dm_req; in the next cycle it SHALL show wb_valid=1, wb_wreg_en=0 and mem_err=1, and stay in IDLE.
REQ-017 In ACCESS, dm_req, dm_we, dm_addr and dm_wdata SHALL stay stable until the cycle dm_ack=1 is sampled.
REQ-018 When dm_ack is sampled in ACCESS, the next cycle SHALL have dm_req=0, state IDLE and wb_valid=1.
REQ-019 For a completed load, wb_wdata SHALL be dm_rdata as sampled with dm_ack, and wb_wreg_en SHALL be the latched ex_wreg_en.
REQ-020 For a completed store, wb_wreg_en SHALL be 0.
REQ-021 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without dm_ack.
REQ-022 If the wait counter reaches MAX_WAIT-1 without dm_ack, the next cycle SHALL have dm_req=0, wb_valid=1, wb_wreg_en=0, mem_err=1 and state IDLE.
REQ-023 dm_ack arriving in the same cycle as the timeout SHALL win: the access completes normally with no mem_err.
REQ-024 dm_ack while in IDLE SHALL be ignored.
REQ-025 wb_valid, ovf_exc and mem_err SHALL be single-cycle pulses; the other wb_* outputs SHALL hold their values between pulses.
REQ-026 Issue throughput SHALL be one non-memory op per cycle; a memory op SHALL occupy at least 2 cycles, since no new operation is accepted in the dm_ack cycle.

Reset
REQ-027 While rst=0, the block SHALL be in state IDLE, and every output and internal register (dm_*, wb_*, ovf_exc, mem_err, wait counter) SHALL be 0.
REQ-028 Asserting rst during ACCESS SHALL drop dm_req immediately (asynchronous) and abandon the transfer with no wb_valid.
REQ-029 After reset release, ex_ready SHALL be 1 in the first cycle.

Structure
REQ-030 Package mem_pkg SHALL hold the state enum, the mem_op encodings, and the MAX_WAIT default; widths SHALL come from port_define.sv macros.
REQ-031 No sub-module SHALL be used: the FSM, the wait counter and the pipeline registers SHALL live in mem_stage.

Verification
REQ-032 The bench SHALL drive add-result 0x0000_0010, wreg 5, op 00 -> and check wb_valid the next cycle with wb_wdata=0x10, wb_wreg_addr=5 and wb_wreg_en=1.
REQ-033 The bench SHALL drive a load from addr 0x100 with dm_ack on the 3rd ACCESS cycle and dm_rdata=0xDEADBEEF -> and check that ex_ready is 0 for 3 cycles, then wb_wdata=0xDEADBEEF, wb_wreg_en=1 and dm_req=0.
REQ-034 The bench SHALL drive a store to addr 0x204 with data 0x1234, MAX_WAIT=16, and no dm_ack -> and check that dm_req is held for 16 cycles, then mem_err=1, wb_wreg_en=0, and the state returns to IDLE.
REQ-035 The bench SHALL drive a load at addr 0x102 -> and check no dm_req, then wb_valid=1 and mem_err=1 the next cycle.
REQ-036 The bench SHALL drive op 00 with ex_overflow=1 and ex_wreg_en=1 -> and check wb_wreg_en=0 and ovf_exc=1.
REQ-037 The bench SHALL assert rst on the 2nd ACCESS cycle of a load -> and check that dm_req falls without a clock edge, that no wb_valid is seen, and that ex_ready=1 after release.
